// File: rtl/data_demux_pkg.sv
// Shared constants and types for the data_demux 1-to-2 handshaked demultiplexer.
package data_demux_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic SEL_CH1 = 1'b0;
    localparam logic SEL_CH2 = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/demux_fifo2.sv
// Per-channel 2-entry FIFO with occupancy FSM, valid/ready handshake and a
// wrapping delivered-word counter. Entry 0 is always the head.
module demux_fifo2
    import data_demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_cnt
);

    occ_e             r_state;
    occ_e             w_state_nxt;
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic             w_pop;
    logic             w_head_from_in;
    logic             w_head_from_tail;
    logic             w_tail_from_in;

    assign w_pop = o_valid && i_ready;

    // Next occupancy and which storage slots load this cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_from_in   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (i_push) begin
                    w_state_nxt    = ST_ONE;
                    w_head_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                case ({i_push, w_pop})
                    2'b11: w_head_from_in = 1'b1;
                    2'b10: begin
                        w_tail_from_in = 1'b1;
                        w_state_nxt    = ST_FULL;
                    end
                    2'b01: w_state_nxt = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_head_from_tail = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Head only moves on a pop or a push into an empty slot, so it holds under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
        end else begin
            if (w_head_from_in)        r_mem[0] <= i_data;
            else if (w_head_from_tail) r_mem[0] <= r_mem[1];
            if (w_tail_from_in)        r_mem[1] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cnt <= '0;
        else if (w_pop) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_full  = (r_state == ST_FULL);
    assign o_valid = (r_state != ST_EMPTY);
    assign o_data  = r_mem[0];
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/data_demux.sv
// Handshaked 1-to-2 demultiplexer: steers each accepted word to one of two
// independently buffered channels by a per-word select bit.
module data_demux
    import data_demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    logic w_sel_ch2;
    logic w_full1;
    logic w_full2;
    logic w_push1;
    logic w_push2;

    // Ready depends only on the select and registered full flags: no ready-to-ready path.
    assign w_sel_ch2 = (in_sel == SEL_CH2);
    assign in_ready  = w_sel_ch2 ? !w_full2 : !w_full1;
    assign w_push1   = in_valid && in_ready && !w_sel_ch2;
    assign w_push2   = in_valid && in_ready &&  w_sel_ch2;

    demux_fifo2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_data  (in_data),
        .o_full  (w_full1),
        .o_valid (out1_valid),
        .o_data  (out1_data),
        .i_ready (out1_ready),
        .o_cnt   (cnt1)
    );

    demux_fifo2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch2 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push2),
        .i_data  (in_data),
        .o_full  (w_full2),
        .o_valid (out2_valid),
        .o_data  (out2_data),
        .i_ready (out2_ready),
        .o_cnt   (cnt2)
    );

endmodule

// File: tb/tb_data_demux.sv
// Self-checking bench for data_demux: vector table plus hand sequences, with a
// per-channel scoreboard that tracks every transfer.
module tb_data_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        out1_valid;
    logic        out1_ready = 1'b0;
    logic [31:0] out1_data;
    logic        out2_valid;
    logic        out2_ready = 1'b0;
    logic [31:0] out2_data;
    logic [15:0] cnt1;
    logic [15:0] cnt2;

    data_demux dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [15:0] m_cnt1 = '0;
    logic [15:0] m_cnt2 = '0;

    typedef struct {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        r1;
        logic        r2;
        logic        e_ir;
        logic        e_v1;
        logic [31:0] e_d1;
        logic        e_v2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Record transfers that the coming edge will perform; inputs are stable here.
    task automatic sample();
        logic [31:0] e;
        if (!rst) begin
            if (in_valid && in_ready) begin
                if (in_sel) q2.push_back(in_data);
                else        q1.push_back(in_data);
            end
            if (out1_valid && out1_ready) begin
                m_cnt1 = m_cnt1 + 16'd1;
                if (q1.size() == 0) chk("sb1_unexpected", out1_data, 32'hDEAD_0001);
                else begin e = q1.pop_front(); chk("sb1_data", out1_data, e); end
            end
            if (out2_valid && out2_ready) begin
                m_cnt2 = m_cnt2 + 16'd1;
                if (q2.size() == 0) chk("sb2_unexpected", out2_data, 32'hDEAD_0002);
                else begin e = q2.pop_front(); chk("sb2_data", out2_data, e); end
            end
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic r1, input logic r2);
        sample();
        @(posedge clk);
        #2;
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out1_ready = r1;
        out2_ready = r2;
        #1;
    endtask

    function automatic vec_t mk(logic v, logic sel, logic [31:0] d, logic r1, logic r2,
                                logic e_ir, logic e_v1, logic [31:0] e_d1,
                                logic e_v2, logic [31:0] e_d2);
        vec_t t;
        t.v = v; t.sel = sel; t.d = d; t.r1 = r1; t.r2 = r2;
        t.e_ir = e_ir; t.e_v1 = e_v1; t.e_d1 = e_d1; t.e_v2 = e_v2; t.e_d2 = e_d2;
        return t;
    endfunction

    initial begin
        int idx;
        int n_pop2;
        logic [15:0] base2;
        int need;
        int pushed;

        // Routing, latency, then channel-2 backpressure isolation.
        vecs[0]  = mk(1, 0, 32'h1111_1111, 1, 1, 1, 0, 32'h0,          0, 32'h0);
        vecs[1]  = mk(1, 1, 32'h2222_2222, 1, 1, 1, 1, 32'h1111_1111, 0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,         1, 1, 1, 0, 32'h0,          1, 32'h2222_2222);
        vecs[3]  = mk(1, 1, 32'hB000_0000, 1, 0, 1, 0, 32'h0,          0, 32'h0);
        vecs[4]  = mk(1, 1, 32'hB000_0001, 1, 0, 1, 0, 32'h0,          1, 32'hB000_0000);
        vecs[5]  = mk(1, 1, 32'hB000_0002, 1, 0, 0, 0, 32'h0,          1, 32'hB000_0000);
        vecs[6]  = mk(1, 0, 32'hA5A5_A5A5, 1, 0, 1, 0, 32'h0,          1, 32'hB000_0000);
        vecs[7]  = mk(0, 0, 32'h0,         1, 0, 1, 1, 32'hA5A5_A5A5, 1, 32'hB000_0000);
        vecs[8]  = mk(0, 1, 32'h0,         1, 1, 0, 0, 32'h0,          1, 32'hB000_0000);
        vecs[9]  = mk(0, 1, 32'h0,         1, 1, 1, 0, 32'h0,          1, 32'hB000_0001);
        vecs[10] = mk(0, 0, 32'h0,         0, 0, 1, 0, 32'h0,          0, 32'h0);

        #3;
        chk("rst_v1", 32'(out1_valid), 32'd0);
        chk("rst_v2", 32'(out2_valid), 32'd0);
        chk("rst_d1", out1_data, 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].r1, vecs[i].r2);
            chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(vecs[i].e_v1));
            chk($sformatf("vec%0d_v2", i), 32'(out2_valid), 32'(vecs[i].e_v2));
            if (vecs[i].e_v1) chk($sformatf("vec%0d_d1", i), out1_data, vecs[i].e_d1);
            if (vecs[i].e_v2) chk($sformatf("vec%0d_d2", i), out2_data, vecs[i].e_d2);
        end
        chk("vec_cnt1", 32'(cnt1), 32'd2);
        chk("vec_cnt2", 32'(cnt2), 32'd3);

        // Simultaneous push and pop in ONE, then pop alone in FULL.
        drive(1, 0, 32'h10, 0, 0);
        drive(1, 0, 32'h20, 1, 0);
        chk("pp_head10", out1_data, 32'h10);
        drive(0, 0, 32'h0, 0, 0);
        chk("pp_v1", 32'(out1_valid), 32'd1);
        chk("pp_head20", out1_data, 32'h20);
        chk("pp_one_ir", 32'(in_ready), 32'd1);
        drive(1, 0, 32'h30, 0, 0);
        drive(1, 0, 32'h40, 1, 0);
        chk("full_pop_ir", 32'(in_ready), 32'd0);
        chk("full_head", out1_data, 32'h20);
        drive(0, 0, 32'h0, 1, 0);
        chk("full_after_pop_ir", 32'(in_ready), 32'd1);
        chk("full_after_pop_d1", out1_data, 32'h30);
        drive(0, 0, 32'h0, 0, 0);
        chk("drained_v1", 32'(out1_valid), 32'd0);
        chk("pp_cnt1", 32'(cnt1), 32'(m_cnt1));

        // Ordering: 0..9 to channel 2 with toggling ready.
        idx = 0;
        n_pop2 = 0;
        base2 = m_cnt2;
        for (int c = 0; c < 200; c++) begin
            drive(idx < 10, 1, 32'(idx), 0, c[0]);
            if (in_valid && in_ready) idx++;
            if (idx == 10 && !out2_valid && q2.size() == 0) break;
        end
        n_pop2 = int'(m_cnt2 - base2);
        chk("ord_pushed", 32'(idx), 32'd10);
        chk("ord_popped", 32'(n_pop2), 32'd10);
        chk("ord_cnt2", 32'(cnt2 - base2), 32'd10);
        chk("ord_q2_empty", 32'(q2.size()), 32'd0);

        // Fill both channels, then reset asynchronously between edges.
        drive(1, 0, 32'hF1, 0, 0);
        drive(1, 0, 32'hF2, 0, 0);
        drive(1, 1, 32'hF3, 0, 0);
        drive(1, 1, 32'hF4, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        chk("prerst_ir1", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_v1", 32'(out1_valid), 32'd0);
        chk("arst_v2", 32'(out2_valid), 32'd0);
        chk("arst_d1", out1_data, 32'd0);
        chk("arst_d2", out2_data, 32'd0);
        chk("arst_cnt1", 32'(cnt1), 32'd0);
        chk("arst_cnt2", 32'(cnt2), 32'd0);
        chk("arst_ir0", 32'(in_ready), 32'd1);
        in_sel = 1'b1;
        #1;
        chk("arst_ir1", 32'(in_ready), 32'd1);
        q1.delete();
        q2.delete();
        m_cnt1 = '0;
        m_cnt2 = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        drive(1, 0, 32'h00C0_FFEE, 1, 0);
        drive(0, 0, 32'h0, 1, 0);
        chk("post_rst_v1", 32'(out1_valid), 32'd1);
        chk("post_rst_d1", out1_data, 32'h00C0_FFEE);
        drive(0, 0, 32'h0, 0, 0);
        chk("post_rst_cnt1", 32'(cnt1), 32'd1);

        // Counter wrap: bring cnt1 to 0xFFFF, then one more pop.
        need = int'(16'hFFFF - m_cnt1);
        pushed = 0;
        base2 = cnt2;
        for (int c = 0; c < 70000; c++) begin
            drive(pushed < need, 0, 32'(c), 1, 0);
            if (in_valid && in_ready) pushed++;
            if (pushed == need && !out1_valid && q1.size() == 0) break;
        end
        chk("wrap_pre_cnt1", 32'(cnt1), 32'h0000_FFFF);
        drive(1, 0, 32'h5A5A_5A5A, 1, 0);
        drive(0, 0, 32'h0, 1, 0);
        drive(0, 0, 32'h0, 0, 0);
        chk("wrap_cnt1", 32'(cnt1), 32'h0000_0000);
        chk("wrap_model", 32'(cnt1), 32'(m_cnt1));
        chk("wrap_cnt2", 32'(cnt2), 32'(base2));
        chk("end_q1_empty", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_demux.md
# data_demux

Handshaked 1-to-2 demultiplexer. It routes each accepted 32-bit word to one of two destination channels according to a per-word select bit. Each destination has its own 2-entry buffer, so a stalled destination never blocks traffic to the other. It sits at the opposite end of the datapath 2:1 select: it steers one producer, such as the write-back or store path, to one of two consumers, such as data memory and the peripheral register bank.

## Interface
Parameters:
- WIDTH, 32, data width of every data port
- CNT_W, 16, width of the per-channel delivered-word counters

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word on in_data/in_sel
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to route
- in_sel  input  1  routing select: 0 sends to channel 1, 1 sends to channel 2
- out1_valid  output  1  channel 1 head word valid
- out1_ready  input  1  channel 1 consumer accepts the head word
- out1_data  output  WIDTH  channel 1 head word
- out2_valid  output  1  channel 2 head word valid
- out2_ready  input  1  channel 2 consumer accepts the head word
- out2_data  output  WIDTH  channel 2 head word
- cnt1  output  CNT_W  count of words popped from channel 1 (wraps)
- cnt2  output  CNT_W  count of words popped from channel 2 (wraps)

## Operation
- Transfer on the input side: in_valid && in_ready at a rising clk edge. Transfer on an output side: outN_valid && outN_ready at a rising edge.
- in_ready = !full of the channel named by in_sel. This is combinational from in_sel and the registered full flags only. It never depends on in_valid or outN_ready.
- An accepted word is pushed into the FIFO of the selected channel only. The other channel is untouched.
- Each channel FIFO holds 2 entries, in order. outN_valid = !empty. outN_data = head entry, registered.
- Each channel has its own occupancy of 0, 1 or 2 with states EMPTY, ONE and FULL:
  - push only: EMPTY→ONE, ONE→FULL.
  - pop only: FULL→ONE, ONE→EMPTY.
  - push and pop in the same cycle: occupancy is unchanged.
  - In ONE, a simultaneous push and pop makes the pushed word the new head.
- FULL with a pop in the same cycle: in_ready is still 0 for that channel. There is no pass-through path from ready to ready.
- outN_data holds its value while outN_valid is 1 and outN_ready is 0. It changes only on a pop or on a push into an EMPTY channel.
- cntN increments by 1 on each output-side transfer of channel N. It wraps from 2^CNT_W−1 to 0.
- Reset (asynchronous, at any time):
  - Both FIFOs become EMPTY and all buffered words are discarded.
  - out1_valid=0, out2_valid=0.
  - out1_data=0, out2_data=0.
  - cnt1=0, cnt2=0.
  - in_ready=1 for either value of in_sel.

## Timing
- Latency is 1 cycle. A word accepted at edge k is visible on outN_valid/outN_data after edge k. It can be consumed at edge k+1 at the earliest.
- Throughput is 1 word per cycle per channel under continuous outN_ready=1. No bubbles occur.
- Words sent to different channels have no ordering relation between them. Order is preserved within each channel.
- While rst is high, no transfers occur. Outputs stay at their reset values. Input transfers resume at the first rising edge after rst deasserts.

## Structure
- Shared package data_demux_pkg:
  - WIDTH_DEF=32, CNT_W_DEF=16
  - FIFO_DEPTH=2
  - SEL_CH1=1'b0, SEL_CH2=1'b1
- Sub-module demux_fifo2 is instantiated once per channel. It holds the 2-entry FIFO, the occupancy state, the valid/ready logic and the wrapping pop counter.
- The top level contains only the in_sel decode, the per-channel push enables, and the in_ready select.

## Test plan
- Routing and latency: push 0x1111_1111 with sel=0, then 0x2222_2222 with sel=1, with both outputs ready.
  - out1 shows 0x1111_1111 one cycle after its accept. out2 shows 0x2222_2222 one cycle after its accept.
  - cnt1=1, cnt2=1. The other channel never asserts valid for either word.
- Isolation under backpressure: hold out2_ready=0 and push 3 words with sel=1.
  - After 2 accepts, in_ready=0 while sel=1.
  - Switching to sel=0 gives in_ready=1, and a word 0xA5A5_A5A5 is delivered on out1.
  - out2_data holds the first sel=1 word throughout.
- Simultaneous push and pop:
  - Channel 1 in ONE holding 0x10: push 0x20 while popping gives out1_data=0x20 and occupancy ONE.
  - Channel 1 in FULL: a pop alone does not raise in_ready in that cycle.
- Ordering: stream 0..9 to channel 2 with out2_ready toggling every cycle.
  - Output sequence is exactly 0..9 with no drops or duplicates. cnt2=10.
- Reset mid-operation: assert rst asynchronously, between edges, with both channels FULL.
  - All valids, data and counters become 0 immediately.
  - in_ready=1. The first post-reset push is delivered normally.
- Counter wrap: preload via 65535 pops on channel 1. The next pop gives cnt1=0x0000 and cnt2 is unaffected.
